// File: rtl/coord_fmt_pkg.sv
// Shared coordinate-format constants for fixed_to_ascii and ascii_to_fixed.
//   - ASCII character constants used in NMEA-style coordinate fields
//   - field lengths and digit counts for latitude / longitude
//   - minutes scale factor (60 min * 10^4 fraction digits)
//   - FSM state encoding for the formatter
package coord_fmt_pkg;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_N   = 8'h4E;
  localparam logic [7:0] CH_S   = 8'h53;
  localparam logic [7:0] CH_E   = 8'h45;
  localparam logic [7:0] CH_W   = 8'h57;

  localparam logic [7:0] LAT_LEN    = 8'd9;
  localparam logic [7:0] LON_LEN    = 8'd10;
  localparam logic [3:0] LAT_DIGITS = 4'd8;
  localparam logic [3:0] LON_DIGITS = 4'd9;
  // mmffff digits produced from the fractional-degree part
  localparam logic [3:0] MF_DIGITS  = 4'd6;

  localparam logic [35:0] MIN_SCALE = 36'd600000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_DIGIT = 2'd2,
    ST_DONE  = 2'd3
  } fmt_state_e;

endpackage

// File: rtl/div10_digit.sv
// Combinational 20-bit divide-by-10.
//   v_i : dividend
//   q_o : v_i / 10
//   r_o : v_i % 10 (one decimal digit)
module div10_digit (
  input  logic [19:0] v_i,
  output logic [19:0] q_o,
  output logic [3:0]  r_o
);

  assign q_o = v_i / 20'd10;
  assign r_o = 4'(v_i - q_o * 20'd10);

endmodule

// File: rtl/fixed_to_ascii.sv
// Signed Q16.16 degrees -> NMEA-style ASCII coordinate field.
// Latitude ddmm.mmmm (9 chars), longitude dddmm.mmmm (10 chars), plus a
// hemisphere character. One decimal digit is extracted per cycle.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : request strobe, taken only while busy=0
//   is_lon      : 1 = longitude format, 0 = latitude format
//   deg_q16_16  : signed degrees, Q16.16
//   busy        : conversion in flight
//   ascii_vec   : characters, byte0 at [127:120]; unused bytes = PAD_CHAR
//   length      : valid character count (9 / 10)
//   hemi        : 'N' / 'S' / 'E' / 'W'
//   range_err   : value was clamped to the degree limit
//   out_valid   : one-cycle completion pulse; other outputs hold until next
//
// Build option: define FIXED_TO_ASCII_ROUND_EN to round the minutes field to
// nearest instead of truncating. Latency is unchanged.
module fixed_to_ascii
  import coord_fmt_pkg::*;
#(
  parameter int unsigned LAT_MAX_DEG = 90,
  parameter int unsigned LON_MAX_DEG = 180,
  parameter logic [7:0]  PAD_CHAR    = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         is_lon,
  input  logic [31:0]  deg_q16_16,
  output logic         busy,
  output logic [127:0] ascii_vec,
  output logic [7:0]   length,
  output logic [7:0]   hemi,
  output logic         range_err,
  output logic         out_valid
);

  localparam logic [15:0] LAT_LIM = 16'(LAT_MAX_DEG);
  localparam logic [15:0] LON_LIM = 16'(LON_MAX_DEG);

  fmt_state_e      state_q;
  logic [31:0]     in_q;
  logic            lon_q;
  logic [19:0]     val_q;
  logic [15:0]     dd_q;
  logic            err_q;
  logic            neg_q;
  logic [3:0]      cnt_q;
  logic [8:0][7:0] digs_q;

  logic            busy_q;
  logic [127:0]    vec_q;
  logic [7:0]      len_q;
  logic [7:0]      hemi_q;
  logic            rerr_q;
  logic            ov_q;

  // ---------------- SCALE datapath (works on captured input) ----------------
  logic [31:0] mag;
  logic [35:0] prod;
  logic [35:0] prod_r;
  logic [19:0] mf_sc;
  logic [15:0] lim;
  logic [15:0] dd_sc;
  logic        clamp;

  // 0x80000000 negates to itself, which reads correctly as 2^31 unsigned
  assign mag  = in_q[31] ? (~in_q + 32'd1) : in_q;
  assign prod = {20'd0, mag[15:0]} * MIN_SCALE;
`ifdef FIXED_TO_ASCII_ROUND_EN
  assign prod_r = prod + 36'd32768;
`else
  assign prod_r = prod;
`endif
  assign lim   = lon_q ? LON_LIM : LAT_LIM;
  assign clamp = mag[31:16] > lim;
  assign dd_sc = clamp ? lim : mag[31:16];
  assign mf_sc = clamp ? 20'd0 : 20'(prod_r >> 16);

  // ---------------- DIGIT datapath ----------------
  logic [19:0]     quo;
  logic [3:0]      rem;
  logic [7:0]      dig_ch;
  logic            last;
  logic [19:0]     val_nxt;
  logic [8:0][7:0] digs_all;
  logic [127:0]    vec_n;

  div10_digit u_div10 (
    .v_i (val_q),
    .q_o (quo),
    .r_o (rem)
  );

  assign dig_ch = CH_0 + {4'd0, rem};
  assign last   = cnt_q == (lon_q ? (LON_DIGITS - 4'd1) : (LAT_DIGITS - 4'd1));
  // after the six minute digits, switch the source over to whole degrees
  assign val_nxt = (cnt_q == MF_DIGITS - 4'd1) ? {4'd0, dd_q} : quo;

  // stored digits plus the one being produced this cycle, so packing can
  // happen on the final DIGIT edge and out_valid lands in the DONE cycle
  always_comb begin
    digs_all        = digs_q;
    digs_all[cnt_q] = dig_ch;
  end

  // digit index 0 is the least significant (last fraction digit)
  always_comb begin
    if (lon_q)
      vec_n = {digs_all[8], digs_all[7], digs_all[6], digs_all[5], digs_all[4],
               CH_DOT, digs_all[3], digs_all[2], digs_all[1], digs_all[0],
               {6{PAD_CHAR}}};
    else
      vec_n = {digs_all[7], digs_all[6], digs_all[5], digs_all[4],
               CH_DOT, digs_all[3], digs_all[2], digs_all[1], digs_all[0],
               {7{PAD_CHAR}}};
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      lon_q   <= 1'b0;
      val_q   <= '0;
      dd_q    <= '0;
      err_q   <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      digs_q  <= '0;
      busy_q  <= 1'b0;
      vec_q   <= '0;
      len_q   <= '0;
      hemi_q  <= '0;
      rerr_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      case (state_q)
        // DONE accepts like IDLE so requests can run back-to-back
        ST_IDLE, ST_DONE: begin
          if (in_valid) begin
            in_q    <= deg_q16_16;
            lon_q   <= is_lon;
            busy_q  <= 1'b1;
            state_q <= ST_SCALE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCALE: begin
          val_q   <= mf_sc;
          dd_q    <= dd_sc;
          err_q   <= clamp;
          neg_q   <= in_q[31] && (mag != 32'd0);
          cnt_q   <= '0;
          state_q <= ST_DIGIT;
        end
        ST_DIGIT: begin
          digs_q[cnt_q] <= dig_ch;
          val_q         <= val_nxt;
          cnt_q         <= cnt_q + 4'd1;
          if (last) begin
            vec_q   <= vec_n;
            len_q   <= lon_q ? LON_LEN : LAT_LEN;
            hemi_q  <= lon_q ? (neg_q ? CH_W : CH_E) : (neg_q ? CH_S : CH_N);
            rerr_q  <= err_q;
            ov_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign ascii_vec = vec_q;
  assign length    = len_q;
  assign hemi      = hemi_q;
  assign range_err = rerr_q;
  assign out_valid = ov_q;

endmodule

// File: doc/fixed_to_ascii.md
Name: fixed_to_ascii

Overview:
Converts a signed Q16.16 degree value into the NMEA-style ASCII coordinate field consumed by ascii_to_fixed. Latitude is formatted as ddmm.mmmm and longitude as dddmm.mmmm, with a hemisphere character alongside. The block sits on the transmit/display path of the coordinate calculator, after the fixed-point arithmetic. It extracts one decimal digit per cycle, so it is small and multi-cycle.

Parameters:
LAT_MAX_DEG, 90, latitude clamp limit in whole degrees
LON_MAX_DEG, 180, longitude clamp limit in whole degrees
PAD_CHAR, 8'h00, fill byte for unused ascii_vec positions

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request strobe, sampled only when busy=0
is_lon  input  1  1 = longitude format, 0 = latitude format
deg_q16_16  input  32  signed two's-complement degrees, Q16.16
busy  output  1  high while a conversion is in flight
ascii_vec  output  128  byte0 at [127:120], then descending
length  output  8  number of valid characters (9 or 10)
hemi  output  8  'N' / 'S' / 'E' / 'W'
range_err  output  1  value was clamped; qualified by out_valid
out_valid  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs are 0 (ascii_vec all zero, length 0, hemi 0). FSM goes to IDLE. Reset asserted mid-conversion aborts it, and no out_valid follows.
- FSM states: IDLE -> SCALE -> DIGIT -> DONE -> IDLE.
- IDLE: busy=0. When in_valid=1, capture deg_q16_16 and is_lon, go to SCALE. This is cycle 0.
- SCALE (1 cycle):
  - neg = bit31 of the input. mag = 32-bit unsigned absolute value (0x80000000 gives 2^31).
  - dd = mag[31:16]. mf = (mag[15:0] * 600000) >> 16, using a 36-bit product and 20-bit result, max 599990.
  - If dd > limit (LAT_MAX_DEG or LON_MAX_DEG): dd = limit, mf = 0, set err.
- DIGIT: one digit per cycle, LSB first.
  - mf supplies 6 digits (mmffff); then dd supplies 2 digits (lat) or 3 digits (lon).
  - Digit count D = 8 (lat) or 9 (lon).
  - Each digit = value % 10 + "0"; value <= value / 10.
- DONE (1 cycle):
  - Pack characters in transmit order; '.' (0x2E) goes after the minutes integer part.
  - Unused bytes are PAD_CHAR. length = 9 (lat) or 10 (lon).
  - hemi = 'S'/'W' if neg and mag != 0, otherwise 'N'/'E'.
  - range_err = err. Pulse out_valid and return to IDLE.
- Latency: out_valid is asserted in cycle 2+D, i.e. cycle 10 for lat and cycle 11 for lon.
- busy is 0 in the out_valid cycle, so a new request may be accepted in that same cycle (back-to-back).
- in_valid while busy=1 is ignored; no queueing.
- Outputs hold their values between completions. Only out_valid pulses.
- Digits are always zero-padded. Leading zeros are kept ("0430.0000").

Optional Feature:
FIXED_TO_ASCII_ROUND_EN
- Defined: mf = (mag[15:0]*600000 + 32768) >> 16, round to nearest. The maximum is 599991, so the minutes field never reaches 60.
- Undefined: the truncating formula above is used.
- Latency is identical in both cases.

Decomposition:
- Shared package coord_fmt_pkg:
  - Character constants: '0', '.', 'N', 'S', 'E', 'W'.
  - LAT_LEN=9, LON_LEN=10, LAT_DIGITS=8, LON_DIGITS=9.
  - MIN_SCALE=600000.
  - FSM state enum.
  - The same package is reused by ascii_to_fixed for its digit/length constants.
- Sub-module div10_digit: combinational 20-bit divide-by-10 giving quotient and remainder, instantiated once in the DIGIT datapath.

Test Plan:
- Lat 0x00048000 (4.5 deg) -> at cycle 10: ascii "0430.0000", length 9, hemi 'N', range_err 0.
- Lon 0xFFB5C000 (-74.25 deg) -> at cycle 11: ascii "07415.0000", length 10, hemi 'W'.
- Lat 0x00000005 -> "0000.0046" with FIXED_TO_ASCII_ROUND_EN defined, "0000.0045" without; hemi 'N'.
- Lat 0x005B0000 (91 deg) -> "9000.0000", range_err 1. Lon 0x80000000 -> "18000.0000", hemi 'W', range_err 1.
- Back-to-back and busy handling:
  - Request accepted in the out_valid cycle -> next out_valid 10 cycles later.
  - in_valid pulsed while busy -> ignored, exactly one out_valid.
- Reset asserted mid-DIGIT -> outputs zero, busy 0; no out_valid after release until a new request.
